// File: rtl/pr_pkg.sv
// Shared definitions for the generic pipeline stage register: state encoding
// (which doubles as the occupancy count) and the all-zero NOP control word.
package pr_pkg;

    typedef enum logic [1:0] {
        PR_ST_EMPTY = 2'd0,
        PR_ST_FULL  = 2'd1,
        PR_ST_SKID  = 2'd2
    } pr_state_e;

    // Wide enough for any control bundle; users slice it to CTRL_WIDTH.
    localparam int PR_CTRL_MAX_WIDTH = 1024;
    localparam logic [PR_CTRL_MAX_WIDTH-1:0] PR_CTRL_NOP = '0;

endpackage

// File: rtl/pr_stall_counter.sv
// Saturating stall-cycle counter: counts enabled cycles, sticks at all-ones,
// cleared only by the asynchronous reset.
module pr_stall_counter #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc_en,
    output logic [CNT_WIDTH-1:0] count
);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc_en && (count != '1)) begin
            count <= count + CNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/pr_stage_generic.sv
// Generic valid/ready pipeline stage register with flush and stall counter.
// Build option PR_STAGE_SKID_EN adds a second (skid) entry and a registered IN_READY.
module pr_stage_generic
    import pr_pkg::*;
#(
    parameter int DATA_WIDTH = 160,
    parameter int CTRL_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  IN_VALID,
    output logic                  IN_READY,
    input  logic [DATA_WIDTH-1:0] IN_DATA,
    input  logic [CTRL_WIDTH-1:0] IN_CTRL,
    output logic                  OUT_VALID,
    input  logic                  OUT_READY,
    output logic [DATA_WIDTH-1:0] OUT_DATA,
    output logic [CTRL_WIDTH-1:0] OUT_CTRL,
    input  logic                  FLUSH,
    output logic [1:0]            OCCUPANCY,
    output logic [CNT_WIDTH-1:0]  STALL_CYCLES
);

    localparam logic [CTRL_WIDTH-1:0] NOP = PR_CTRL_NOP[CTRL_WIDTH-1:0];

    pr_state_e             state;
    logic [DATA_WIDTH-1:0] main_data;
    logic [CTRL_WIDTH-1:0] main_ctrl;
    logic                  ready;
    logic                  accept;
    logic                  emit;

`ifdef PR_STAGE_SKID_EN
    logic [DATA_WIDTH-1:0] skid_data;
    logic [CTRL_WIDTH-1:0] skid_ctrl;
    logic                  ready_q;

    // Registered ready breaks the OUT_READY -> IN_READY combinational chain.
    assign ready = ready_q;
`else
    assign ready = (state == PR_ST_EMPTY) || OUT_READY;
`endif

    assign OUT_VALID = (state != PR_ST_EMPTY);
    assign accept    = IN_VALID && ready;
    assign emit      = OUT_VALID && OUT_READY;
    assign IN_READY  = ready;
    assign OUT_DATA  = main_data;
    assign OUT_CTRL  = main_ctrl;
    assign OCCUPANCY = state;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            // NOTE: the data registers are reset too, so OUT_DATA is defined
            // before the first bundle ever arrives.
            state     <= PR_ST_EMPTY;
            main_data <= '0;
            main_ctrl <= NOP;
`ifdef PR_STAGE_SKID_EN
            skid_data <= '0;
            skid_ctrl <= NOP;
            ready_q   <= 1'b1;
`endif
        end else if (FLUSH) begin
            // Squash drops held bundles and any simultaneous incoming one.
            state     <= PR_ST_EMPTY;
            main_ctrl <= NOP;
`ifdef PR_STAGE_SKID_EN
            skid_ctrl <= NOP;
            ready_q   <= 1'b1;
`endif
        end else begin
            case (state)
                PR_ST_EMPTY: begin
                    if (accept) begin
                        main_data <= IN_DATA;
                        main_ctrl <= IN_CTRL;
                        state     <= PR_ST_FULL;
                    end
                end
                PR_ST_FULL: begin
                    if (accept && emit) begin
                        main_data <= IN_DATA;
                        main_ctrl <= IN_CTRL;
`ifdef PR_STAGE_SKID_EN
                    end else if (accept) begin
                        skid_data <= IN_DATA;
                        skid_ctrl <= IN_CTRL;
                        state     <= PR_ST_SKID;
                        ready_q   <= 1'b0;
`endif
                    end else if (emit) begin
                        main_ctrl <= NOP;
                        state     <= PR_ST_EMPTY;
                    end
                end
`ifdef PR_STAGE_SKID_EN
                PR_ST_SKID: begin
                    if (emit) begin
                        main_data <= skid_data;
                        main_ctrl <= skid_ctrl;
                        skid_ctrl <= NOP;
                        state     <= PR_ST_FULL;
                        ready_q   <= 1'b1;
                    end
                end
`endif
                default: begin
                    main_ctrl <= NOP;
                    state     <= PR_ST_EMPTY;
                end
            endcase
        end
    end

    pr_stall_counter #(
        .CNT_WIDTH(CNT_WIDTH)
    ) u_stall_counter (
        .clk   (CLK),
        .rst   (RESET),
        .inc_en(OUT_VALID && !OUT_READY),
        .count (STALL_CYCLES)
    );

endmodule
